rob_mc: RTL

Parametrised reorder buffer for the out-of-order RISC-V core, successor to the single-commit ROB. Sits between dispatch, which allocates entries in program order, and the register file, store buffer and fetch unit, which receive in-order commits and redirects. Adds configurable depth, N writeback ports, up-to-COMMIT_W retirements per cycle, single-cycle JALR retirement and explicit per-entry valid bits for flush safety.

---
 rtl/rob_mc_pkg.sv | 35 +++
 rtl/rob_mc_commit_sel.sv | 51 +++++
 rtl/rob_mc.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/rob_mc_pkg.sv
// Shared types for the multi-commit reorder buffer: instruction kinds,
// the per-entry record and small helpers used by the top and commit scanner.
package rob_mc_pkg;

    typedef enum logic [2:0] {
        K_ALU    = 3'd0,
        K_LOAD   = 3'd1,
        K_STORE  = 3'd2,
        K_BRANCH = 3'd3,
        K_JAL    = 3'd4,
        K_JALR   = 3'd5
    } kind_t;

    typedef struct packed {
        logic        valid;
        logic        ready;
        kind_t       kind;
        logic [4:0]  dest;
        logic [31:0] value;
        logic        mispred;
        logic [31:0] target;
    } entry_t;

    localparam entry_t ENTRY_NOP = '0;

    function automatic int tag_w(input int depth);
        return $clog2(depth);
    endfunction

    // Kinds that produce an architectural register result (link address for jumps).
    function automatic logic writes_rd(input kind_t k);
        return (k == K_ALU) || (k == K_LOAD) || (k == K_JAL) || (k == K_JALR);
    endfunction

endpackage

// File: rtl/rob_mc_commit_sel.sv
// Combinational in-order scan of the oldest COMMIT_W entries: how many retire,
// which slots write the register file, whether a store retires, and redirect.
module rob_mc_commit_sel
    import rob_mc_pkg::*;
#(
    parameter int COMMIT_W = 2
) (
    input  logic              slot_valid   [COMMIT_W],
    input  logic              slot_ready   [COMMIT_W],
    input  logic              slot_mispred [COMMIT_W],
    input  kind_t             slot_kind    [COMMIT_W],
    input  logic [4:0]        slot_dest    [COMMIT_W],
    input  logic [31:0]       slot_target  [COMMIT_W],
    output logic [2:0]        retire_cnt,
    output logic [COMMIT_W-1:0] we,
    output logic              store,
    output logic              redirect,
    output logic [31:0]       redirect_pc
);

    logic stop;

    always_comb begin
        retire_cnt  = 3'd0;
        we          = '0;
        store       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        stop        = 1'b0;
        for (int i = 0; i < COMMIT_W; i++) begin
            if (!stop) begin
                if (!slot_valid[i] || !slot_ready[i]) begin
                    stop = 1'b1;
                end else if (slot_kind[i] == K_STORE && store) begin
                    // Only one store port downstream: a second store waits a cycle.
                    stop = 1'b1;
                end else begin
                    retire_cnt = retire_cnt + 3'd1;
                    we[i]      = writes_rd(slot_kind[i]) && (slot_dest[i] != 5'd0);
                    if (slot_kind[i] == K_STORE) store = 1'b1;
                    if (slot_mispred[i]) begin
                        redirect    = 1'b1;
                        redirect_pc = slot_target[i];
                        stop        = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/rob_mc.sv
// Reorder buffer with NWB writeback ports and up to COMMIT_W in-order retirements
// per cycle; a mispredicting entry retires and then flushes the whole buffer.
module rob_mc
    import rob_mc_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int NWB      = 3,
    parameter int COMMIT_W = 2,
    parameter int TAG_W    = tag_w(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    alloc_valid,
    input  logic [4:0]              alloc_dest,
    input  logic [2:0]              alloc_kind,
    output logic                    alloc_ready,
    output logic [TAG_W-1:0]        alloc_tag,
    input  logic [NWB-1:0]          wb_valid,
    input  logic [NWB*TAG_W-1:0]    wb_tag,
    input  logic [NWB*32-1:0]       wb_value,
    input  logic [NWB-1:0]          wb_mispred,
    input  logic [NWB*32-1:0]       wb_target,
    output logic [COMMIT_W-1:0]     cmt_we,
    output logic [COMMIT_W*5-1:0]   cmt_rd,
    output logic [COMMIT_W*32-1:0]  cmt_value,
    output logic                    cmt_store,
    output logic                    redirect_valid,
    output logic [31:0]             redirect_pc,
    output logic [TAG_W-1:0]        head_tag,
    output logic [TAG_W-1:0]        tail_tag,
    output logic [TAG_W:0]          count,
    output logic                    empty,
    output logic                    full
);

    logic [TAG_W:0]   head, tail;
    entry_t           ent [DEPTH];

    logic [TAG_W-1:0] slot_idx     [COMMIT_W];
    logic             s_valid      [COMMIT_W];
    logic             s_ready      [COMMIT_W];
    logic             s_mispred    [COMMIT_W];
    kind_t            s_kind       [COMMIT_W];
    logic [4:0]       s_dest       [COMMIT_W];
    logic [31:0]      s_value      [COMMIT_W];
    logic [31:0]      s_target     [COMMIT_W];

    logic [2:0]          retire_cnt;
    logic [COMMIT_W-1:0] sel_we;
    logic                sel_store, sel_redirect;
    logic [31:0]         sel_pc;
    logic                alloc_acc;

    assign count       = tail - head;
    assign empty       = (count == '0);
    assign full        = (count == (TAG_W+1)'(DEPTH));
    assign head_tag    = head[TAG_W-1:0];
    assign tail_tag    = tail[TAG_W-1:0];
    assign alloc_tag   = tail[TAG_W-1:0];
    // Dispatch handshake: an entry is taken on a rising edge where alloc_valid and
    // alloc_ready are both high and rdy is high; alloc_tag names it in that cycle.
    assign alloc_ready = !full;
    assign alloc_acc   = alloc_valid && alloc_ready;

    for (genvar k = 0; k < COMMIT_W; k++) begin : g_slot
        assign slot_idx[k]  = head[TAG_W-1:0] + TAG_W'(k);
        assign s_valid[k]   = ent[slot_idx[k]].valid;
        assign s_ready[k]   = ent[slot_idx[k]].ready;
        assign s_mispred[k] = ent[slot_idx[k]].mispred;
        assign s_kind[k]    = ent[slot_idx[k]].kind;
        assign s_dest[k]    = ent[slot_idx[k]].dest;
        assign s_value[k]   = ent[slot_idx[k]].value;
        assign s_target[k]  = ent[slot_idx[k]].target;
    end

    rob_mc_commit_sel #(.COMMIT_W(COMMIT_W)) u_sel (
        .slot_valid   (s_valid),
        .slot_ready   (s_ready),
        .slot_mispred (s_mispred),
        .slot_kind    (s_kind),
        .slot_dest    (s_dest),
        .slot_target  (s_target),
        .retire_cnt   (retire_cnt),
        .we           (sel_we),
        .store        (sel_store),
        .redirect     (sel_redirect),
        .redirect_pc  (sel_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head           <= '0;
            tail           <= '0;
            for (int i = 0; i < DEPTH; i++) ent[i] <= ENTRY_NOP;
            cmt_we         <= '0;
            cmt_rd         <= '0;
            cmt_value      <= '0;
            cmt_store      <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'h0;
        end else if (!rdy) begin
            cmt_we         <= '0;
            cmt_store      <= 1'b0;
            redirect_valid <= 1'b0;
        end else begin
            cmt_we         <= sel_we;
            cmt_store      <= sel_store;
            redirect_valid <= sel_redirect;
            redirect_pc    <= sel_pc;
            for (int k = 0; k < COMMIT_W; k++) begin
                cmt_rd[k*5 +: 5]     <= s_dest[k];
                cmt_value[k*32 +: 32] <= s_value[k];
            end
            if (sel_redirect) begin
                // Younger work is wrong-path: drop it, including this cycle's alloc/writebacks.
                for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
                head <= '0;
                tail <= '0;
            end else begin
                for (int p = 0; p < NWB; p++) begin
                    if (wb_valid[p] && ent[wb_tag[p*TAG_W +: TAG_W]].valid) begin
                        ent[wb_tag[p*TAG_W +: TAG_W]].ready   <= 1'b1;
                        ent[wb_tag[p*TAG_W +: TAG_W]].value   <= wb_value[p*32 +: 32];
                        ent[wb_tag[p*TAG_W +: TAG_W]].mispred <= wb_mispred[p];
                        ent[wb_tag[p*TAG_W +: TAG_W]].target  <= wb_target[p*32 +: 32];
                    end
                end
                for (int k = 0; k < COMMIT_W; k++) begin
                    if (3'(k) < retire_cnt) ent[slot_idx[k]].valid <= 1'b0;
                end
                if (alloc_acc) begin
                    ent[tail[TAG_W-1:0]] <= '{valid: 1'b1, ready: 1'b0, kind: kind_t'(alloc_kind),
                                              dest: alloc_dest, value: 32'h0, mispred: 1'b0,
                                              target: 32'h0};
                end
                head <= head + (TAG_W+1)'(retire_cnt);
                tail <= tail + {{TAG_W{1'b0}}, alloc_acc};
            end
        end
    end

endmodule
